// File: rtl/a2d_scan_ctrl.sv
// SPI master for an ADC128S-style A2D: scans channels round-robin
// and keeps the latest 12-bit result of each one for a host read port.
module a2d_scan_ctrl #(
    parameter int SCLK_DIV = 32,
    parameter int NUM_CH   = 8,
    parameter int SCAN_GAP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    input  logic [2:0]  rd_chnl,
    output logic [11:0] rd_data,
    output logic [7:0]  res_vld,
    output logic        scan_done
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int CMAX = (SCLK_DIV > SCAN_GAP) ? SCLK_DIV : SCAN_GAP;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [1:0] {IDLE, SHIFT, BACK, GAP} state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_bit;
    logic [14:0] r_tx;
    logic [11:0] r_rx;
    logic [2:0]  r_chnl;
    logic [2:0]  r_prv;
    logic        r_first;
    logic        r_ss_n;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_done;
    logic [7:0]  r_vld;
    logic [11:0] r_res [8];

    logic        w_start;
    logic        w_rise;
    logic        w_fall;
    logic        w_end;
    logic        w_back_end;
    logic        w_cnt_half;
    logic        w_cnt_last;
    logic        w_gap_last;
    logic [15:0] w_cmd;

    assign w_cmd      = {2'b00, r_chnl, 11'b0};
    assign w_cnt_half = (r_cnt == CW'(HALF - 1));
    assign w_cnt_last = (r_cnt == CW'(SCLK_DIV - 1));
    assign w_gap_last = (r_cnt == CW'(SCAN_GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_start    = 1'b0;
        w_rise     = 1'b0;
        w_fall     = 1'b0;
        w_end      = 1'b0;
        w_back_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_nxt   = SHIFT;
                    w_start = 1'b1;
                end
            end
            SHIFT: begin
                w_rise = w_cnt_half;
                if (w_cnt_last) begin
                    if (r_bit == 4'd15) begin
                        w_nxt = BACK;
                        w_end = 1'b1;
                    end else begin
                        w_fall = 1'b1;
                    end
                end
            end
            BACK: begin
                if (w_cnt_half) begin
                    w_nxt      = GAP;
                    w_back_end = 1'b1;
                end
            end
            GAP: begin
                if (w_gap_last) begin
                    if (en) begin
                        w_nxt   = SHIFT;
                        w_start = 1'b1;
                    end else begin
                        w_nxt = IDLE;
                    end
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_chnl  <= '0;
            r_prv   <= '0;
            r_first <= 1'b1;
            r_ss_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
            r_vld   <= '0;
            for (int i = 0; i < 8; i++) r_res[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start || w_fall || w_end || w_back_end || r_state == IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            // Period 1 falls together with SS_n; its edge shifts nothing.
            if (w_start) begin
                r_tx   <= w_cmd[14:0];
                r_mosi <= w_cmd[15];
                r_ss_n <= 1'b0;
                r_sclk <= 1'b0;
                r_bit  <= '0;
            end
            if (w_fall) begin
                r_tx   <= {r_tx[13:0], 1'b0};
                r_mosi <= r_tx[14];
                r_sclk <= 1'b0;
                r_bit  <= r_bit + 4'd1;
            end
            if (w_rise) begin
                r_sclk <= 1'b1;
                r_rx   <= {r_rx[10:0], MISO};
            end
            if (w_end) begin
                if (!r_first) begin
                    r_res[r_prv] <= r_rx;
                    r_vld[r_prv] <= 1'b1;
                    r_done       <= (r_prv == 3'(NUM_CH - 1));
                end
                r_first <= 1'b0;
                r_prv   <= r_chnl;
                r_chnl  <= (r_chnl == 3'(NUM_CH - 1)) ? 3'd0 : r_chnl + 3'd1;
            end
            if (w_back_end)
                r_ss_n <= 1'b1;
            // Pipelined protocol: the first frame after idling returns stale data.
            if (r_state == GAP && w_gap_last && !en)
                r_first <= 1'b1;
        end
    end

    assign SS_n      = r_ss_n;
    assign SCLK      = r_sclk;
    assign MOSI      = r_mosi;
    assign res_vld   = r_vld;
    assign scan_done = r_done;
    assign rd_data   = ({1'b0, rd_chnl} < 4'(NUM_CH)) ? r_res[rd_chnl] : 12'h000;

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Bench for a2d_scan_ctrl with an echoing ADC128S-style slave model.
// Directed frames plus a table of steady-state read-port vectors.
module tb_a2d_scan_ctrl;

    localparam int DIV = 8;
    localparam int NCH = 8;
    localparam int GP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [2:0]  rd_chnl = 3'd0;
    logic [11:0] rd_data;
    logic [7:0]  res_vld;
    logic        scan_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    a2d_scan_ctrl #(.SCLK_DIV(DIV), .NUM_CH(NCH), .SCAN_GAP(GP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .rd_chnl(rd_chnl), .rd_data(rd_data),
        .res_vld(res_vld), .scan_done(scan_done)
    );

    // Slave echoes the previous frame's MOSI word; first reply is 0xABCD.
    logic [15:0] s_last = 16'hABCD;
    logic [15:0] s_out = 16'h0;
    logic [15:0] s_rx = 16'h0;
    logic [15:0] s_word = 16'h0;
    logic [4:0]  s_cnt = 5'd0;

    always @(negedge SS_n) begin
        s_out = s_last;
        s_cnt = 5'd0;
        s_rx  = 16'h0;
    end

    always @(posedge SCLK) begin
        if (!SS_n) begin
            s_rx  = {s_rx[14:0], MOSI};
            s_cnt = s_cnt + 5'd1;
        end
    end

    always @(posedge SS_n) begin
        if (s_cnt != 5'd0) begin
            s_last = s_rx;
            s_word = s_rx;
        end
    end

    assign MISO = (s_cnt < 5'd16) ? s_out[4'd15 - s_cnt[3:0]] : 1'b0;

    int   falls = 0;
    int   fr_falls = 0;
    int   edges = 0;
    int   sd_cnt = 0;
    logic p_sclk = 1'b1;
    logic p_ss = 1'b1;

    always @(negedge clk) begin
        if (p_sclk != SCLK) edges <= edges + 1;
        if (scan_done) sd_cnt <= sd_cnt + 1;
        if (!p_ss && SS_n) begin
            fr_falls <= falls;
            falls    <= 0;
        end else if (p_sclk && !SCLK && !SS_n) begin
            falls <= falls + 1;
        end
        p_sclk <= SCLK;
        p_ss   <= SS_n;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_end();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (!p_ss && SS_n) seen = 1'b1;
        end
        #1;
        check("frame_end_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_ss_low();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!SS_n) seen = 1'b1;
        end
        check("frame_start_timeout", 32'(seen), 32'd1);
    endtask

    task automatic frame(input string nm, input logic [15:0] mosi);
        wait_end();
        check({nm, "_falls"}, 32'(fr_falls), 32'd16);
        check({nm, "_mosi"}, 32'(s_word), 32'(mosi));
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
    } rd_vec_t;

    rd_vec_t vecs [8];
    int      e0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].ch   = 3'(i);
            vecs[i].data = (i % 2 == 1) ? 12'h800 : 12'h000;
        end

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_sclk", 32'(SCLK), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_vld", 32'(res_vld), 32'h0);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_rd", 32'(rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("idle_edges", 32'(edges), 32'd0);
        check("idle_ss_n", 32'(SS_n), 32'd1);

        en = 1'b1;
        frame("f1", 16'h0000);
        check("f1_vld", 32'(res_vld), 32'h00);
        frame("f2", 16'h0800);
        check("f2_vld", 32'(res_vld), 32'h01);
        rd_chnl = 3'd0;
        #1 check("f2_rd0", 32'(rd_data), 32'h000);
        frame("f3", 16'h1000);
        check("f3_vld", 32'(res_vld), 32'h03);
        rd_chnl = 3'd1;
        #1 check("f3_rd1", 32'(rd_data), 32'h800);

        for (int f = 4; f <= 17; f++) begin
            frame($sformatf("f%0d", f), 16'(((f - 1) % 8) << 11));
            if (f == 8) check("f8_done", 32'(sd_cnt), 32'd0);
            if (f == 9) check("f9_done", 32'(sd_cnt), 32'd1);
        end
        check("scan_done_cnt", 32'(sd_cnt), 32'd2);
        check("steady_vld", 32'(res_vld), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            rd_chnl = vecs[i].ch;
            #1;
            check($sformatf("rd_ch%0d", i), 32'(rd_data), 32'(vecs[i].data));
        end

        frame("f18", 16'h0800);
        frame("f19", 16'h1000);
        wait_ss_low();
        repeat (7 * DIV + 3) @(negedge clk);
        en = 1'b0;
        frame("f20_drop", 16'h1800);
        check("drop_done", 32'(sd_cnt), 32'd2);
        e0 = edges;
        repeat (40) @(negedge clk);
        #1;
        check("drop_idle_edges", 32'(edges - e0), 32'd0);
        check("drop_idle_ss_n", 32'(SS_n), 32'd1);

        s_last = 16'h0ABC;
        en = 1'b1;
        frame("re1", 16'h2000);
        rd_chnl = 3'd3;
        #1 check("re1_discard", 32'(rd_data), 32'h800);
        check("re1_done", 32'(sd_cnt), 32'd2);

        wait_ss_low();
        repeat (40) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ss_n", 32'(SS_n), 32'd1);
        check("arst_sclk", 32'(SCLK), 32'd1);
        check("arst_vld", 32'(res_vld), 32'h00);
        check("arst_mosi", 32'(MOSI), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // The abandoned frame shows up as a short SS_n pulse; skip it.
        frame("ra1", 16'h0000);
        check("ra1_vld", 32'(res_vld), 32'h00);
        frame("ra2", 16'h0800);
        check("ra2_vld", 32'(res_vld), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
